set_job_dispatcher: RTL and testbench

//  Upstream feeder for the SET candidate-counting engine. Buffers circle-set jobs
//  (central, radius, mode) in a FIFO and issues them one at a time over SET's en/busy

---
 rtl/set_job_dispatcher_if.sv | 45 ++++
 rtl/set_job_dispatcher.sv | 173 +++++++++++++++++
 tb/tb_set_job_dispatcher.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/set_job_dispatcher_if.sv
// Bus bundle between the job producer, the SET engine and the result consumer.
// The dispatcher uses the master modport. The environment uses the slave modport.
interface set_job_dispatcher_if #(
  parameter int TAG_W = 6
);
  // job input side
  logic              job_valid;
  logic              job_ready;
  logic [23:0]       job_central;
  logic [11:0]       job_radius;
  logic [1:0]        job_mode;
  // SET engine side
  logic              set_en;
  logic [23:0]       set_central;
  logic [11:0]       set_radius;
  logic [1:0]        set_mode;
  logic              set_busy;
  logic              set_valid;
  logic [7:0]        set_candidate;
  // result side
  logic              res_valid;
  logic              res_ready;
  logic [7:0]        res_candidate;
  logic [TAG_W-1:0]  res_tag;
  logic [1:0]        res_mode;
  logic              res_err;

  modport master (
    input  job_valid, job_central, job_radius, job_mode,
    input  set_busy, set_valid, set_candidate,
    input  res_ready,
    output job_ready,
    output set_en, set_central, set_radius, set_mode,
    output res_valid, res_candidate, res_tag, res_mode, res_err
  );

  modport slave (
    output job_valid, job_central, job_radius, job_mode,
    output set_busy, set_valid, set_candidate,
    output res_ready,
    input  job_ready,
    input  set_en, set_central, set_radius, set_mode,
    input  res_valid, res_candidate, res_tag, res_mode, res_err
  );
endinterface

// File: rtl/set_job_dispatcher.sv
// set_job_dispatcher: buffers circle-set jobs in a FIFO and issues them to SET
// one at a time. Each SET result is returned on a valid/ready port, tagged with the job's sequence number.
// Optional macro SET_DISP_TIMEOUT_EN adds a watchdog on the WAIT state. On expiry it
// returns candidate 0 with res_err set.
module set_job_dispatcher #(
  parameter int DEPTH       = 4,
  parameter int TAG_W       = 6,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  set_job_dispatcher_if.master  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [23:0]      central;
    logic [11:0]      radius;
    logic [1:0]       mode;
    logic [TAG_W-1:0] tag;
  } job_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_HOLD} state_t;

  job_t             fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [TAG_W-1:0] tag_cnt_q;
  state_t           state_q;
  state_t           state_d;

  logic             set_en_q;
  logic [23:0]      set_central_q;
  logic [11:0]      set_radius_q;
  logic [1:0]       set_mode_q;
  logic [TAG_W-1:0] cur_tag_q;
  logic             res_valid_q;
  logic [7:0]       res_candidate_q;
  logic             res_err_q;

  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic             wd_expire_s;

  // job_ready comes from the registered count, so a pop in the same cycle does not let a push into a full FIFO.
  assign full_s  = (count_q == CNT_W'(DEPTH));
  assign empty_s = (count_q == {CNT_W{1'b0}});
  assign push_s  = bus.job_valid && !full_s;
  assign pop_s   = (state_q == ST_IDLE) && !empty_s && !bus.set_busy;

`ifdef SET_DISP_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wait_cnt_q;

  // watchdog: cleared on ISSUE, counts WAIT cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= {WD_W{1'b0}};
    end else if (state_q == ST_ISSUE) begin
      wait_cnt_q <= {WD_W{1'b0}};
    end else if (state_q == ST_WAIT) begin
      wait_cnt_q <= wait_cnt_q + WD_W'(1);
    end
  end

  // expiry fires on the TIMEOUT_CYC-th WAIT cycle
  assign wd_expire_s = (state_q == ST_WAIT) && (wait_cnt_q == WD_W'(TIMEOUT_CYC - 1));
`else
  assign wd_expire_s = 1'b0;
`endif

  // job FIFO storage, pointers, occupancy and push-side tag counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
      tag_cnt_q <= {TAG_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_q[wr_ptr_q] <= '{central: bus.job_central, radius: bus.job_radius,
                              mode: bus.job_mode, tag: tag_cnt_q};
        wr_ptr_q  <= wr_ptr_q + PTR_W'(1);
        tag_cnt_q <= tag_cnt_q + TAG_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FSM next-state logic: one job in flight, valid wins over watchdog expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pop_s) state_d = ST_ISSUE;
        else       state_d = ST_IDLE;
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.set_valid || wd_expire_s) state_d = ST_HOLD;
        else                              state_d = ST_WAIT;
      end
      ST_HOLD: begin
        if (bus.res_ready) state_d = ST_IDLE;
        else               state_d = ST_HOLD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // registered outputs: issue pulse, job fields latched at pop, result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_en_q        <= 1'b0;
      set_central_q   <= 24'h000000;
      set_radius_q    <= 12'h000;
      set_mode_q      <= 2'b00;
      cur_tag_q       <= {TAG_W{1'b0}};
      res_valid_q     <= 1'b0;
      res_candidate_q <= 8'h00;
      res_err_q       <= 1'b0;
    end else begin
      set_en_q    <= (state_d == ST_ISSUE);
      res_valid_q <= (state_d == ST_HOLD);
      if (pop_s) begin
        set_central_q <= fifo_q[rd_ptr_q].central;
        set_radius_q  <= fifo_q[rd_ptr_q].radius;
        set_mode_q    <= fifo_q[rd_ptr_q].mode;
        cur_tag_q     <= fifo_q[rd_ptr_q].tag;
      end
      if ((state_q == ST_WAIT) && bus.set_valid) begin
        res_candidate_q <= bus.set_candidate;
        res_err_q       <= 1'b0;
      end else if (wd_expire_s) begin
        res_candidate_q <= 8'h00;
        res_err_q       <= 1'b1;
      end
    end
  end

  assign bus.job_ready     = !full_s;
  assign bus.set_en        = set_en_q;
  assign bus.set_central   = set_central_q;
  assign bus.set_radius    = set_radius_q;
  assign bus.set_mode      = set_mode_q;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_candidate = res_candidate_q;
  assign bus.res_tag       = cur_tag_q;
  assign bus.res_mode      = set_mode_q;
  assign bus.res_err       = res_err_q;

endmodule

// File: tb/tb_set_job_dispatcher.sv
// Testbench for set_job_dispatcher.
// The bench uses a behavioural SET engine with random latency and a random-ready consumer.
// A queue-based scoreboard checks issue order, result order, tags, modes and candidates.
module tb_set_job_dispatcher;
  localparam int DEPTH       = 4;
  localparam int TAG_W       = 6;
  localparam int TIMEOUT_CYC = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  set_job_dispatcher_if #(.TAG_W(TAG_W)) bus ();

  set_job_dispatcher #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [23:0] central;
    logic [11:0] radius;
    logic [1:0]  mode;
    int          tag;
    bit          timeout;
  } job_t;

  job_t issue_q[$];
  job_t res_q[$];
  int   push_seq  = 0;
  int   n_results = 0;
  int   n_en      = 0;
  int   n_cmp     = 0;
  int   n_bad     = 0;

  bit          busy_force    = 1'b0;
  bit          never_respond = 1'b0;
  bit          ovr_en        = 1'b0;
  logic [7:0]  ovr_val       = 8'h00;
  int          lat_min       = 1;
  int          lat_max       = 6;
  int          rdy_pct       = 100;
  bit          rdy_hold_low  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // candidate that the SET stand-in computes for a job
  function automatic logic [7:0] cand_of(logic [23:0] c, logic [11:0] r, logic [1:0] m);
    return c[7:0] ^ c[15:8] ^ c[23:16] ^ r[7:0] ^ {r[11:8], 2'b00, m};
  endfunction

  function automatic logic [7:0] exp_cand(job_t j);
    return ovr_en ? ovr_val : cand_of(j.central, j.radius, j.mode);
  endfunction

  // SET engine stand-in: latches job on en, busy until it strobes valid after a latency
  initial begin
    int          cnt;
    bit          active;
    logic [23:0] c;
    logic [11:0] r;
    logic [1:0]  m;
    active = 1'b0;
    cnt = 0;
    bus.set_busy = 1'b0;
    bus.set_valid = 1'b0;
    bus.set_candidate = 8'h00;
    forever begin
      @(posedge clk); #1;
      bus.set_valid = 1'b0;
      if (rst) begin
        active = 1'b0;
      end else if (active) begin
        cnt--;
        if (cnt == 0) begin
          active = 1'b0;
          bus.set_valid = 1'b1;
          bus.set_candidate = ovr_en ? ovr_val : cand_of(c, r, m);
        end
      end else if (bus.set_en && !never_respond) begin
        active = 1'b1;
        cnt = int'($urandom_range(lat_max, lat_min));
        c = bus.set_central;
        r = bus.set_radius;
        m = bus.set_mode;
      end
      bus.set_busy = busy_force || active;
    end
  end

  // result consumer with random ready
  initial begin
    bus.res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.res_ready = !rdy_hold_low && (int'($urandom_range(99, 0)) < rdy_pct);
    end
  end

  // scoreboard: observes handshakes at negedge, which precede the accepting posedge
  initial begin
    bit   prev_en;
    job_t j;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        issue_q.delete();
        res_q.delete();
        push_seq = 0;
        prev_en = 1'b0;
      end else begin
        if (bus.job_valid && bus.job_ready) begin
          j.central = bus.job_central;
          j.radius  = bus.job_radius;
          j.mode    = bus.job_mode;
          j.tag     = push_seq % (1 << TAG_W);
          j.timeout = 1'b0;
          issue_q.push_back(j);
          push_seq++;
        end
        if (bus.set_en) begin
          n_en++;
          check_eq("en_width", 32'(prev_en), 32'd0);
          check_eq("en_in_hold", 32'(bus.res_valid), 32'd0);
          if (issue_q.size() == 0) begin
            check_eq("en_unexpected", 32'(bus.set_en), 32'd0);
          end else begin
            j = issue_q.pop_front();
            check_eq("set_central", 32'(bus.set_central), 32'(j.central));
            check_eq("set_radius", 32'(bus.set_radius), 32'(j.radius));
            check_eq("set_mode", 32'(bus.set_mode), 32'(j.mode));
            j.timeout = never_respond;
            res_q.push_back(j);
          end
        end
        prev_en = bus.set_en;
        if (bus.res_valid && bus.res_ready) begin
          if (res_q.size() == 0) begin
            check_eq("res_unexpected", 32'(bus.res_valid), 32'd0);
          end else begin
            j = res_q.pop_front();
            check_eq("res_tag", 32'(bus.res_tag), 32'(j.tag));
            check_eq("res_mode", 32'(bus.res_mode), 32'(j.mode));
            check_eq("res_candidate", 32'(bus.res_candidate),
                     j.timeout ? 32'd0 : 32'(exp_cand(j)));
            check_eq("res_err", 32'(bus.res_err), 32'(j.timeout));
          end
          n_results++;
        end
      end
    end
  end

  // offer one job and hold it until accepted; returns 1ns after the accepting edge
  task automatic push_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    bus.job_valid   = 1'b1;
    bus.job_central = c;
    bus.job_radius  = r;
    bus.job_mode    = m;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (bus.job_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus.job_valid = 1'b0;
    check_eq("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic push_rand();
    push_job(24'($urandom()), 12'($urandom()), 2'($urandom_range(3, 0)));
  endtask

  task automatic wait_results(input int target, input int budget);
    for (int k = 0; k < budget && n_results < target; k++) @(posedge clk);
    check_eq("results_by_deadline", 32'(n_results), 32'(target));
  endtask

  task automatic check_idle_outputs(input string pfx);
    check_eq({pfx, "_job_ready"}, 32'(bus.job_ready), 32'd1);
    check_eq({pfx, "_set_en"}, 32'(bus.set_en), 32'd0);
    check_eq({pfx, "_set_central"}, 32'(bus.set_central), 32'd0);
    check_eq({pfx, "_set_radius"}, 32'(bus.set_radius), 32'd0);
    check_eq({pfx, "_set_mode"}, 32'(bus.set_mode), 32'd0);
    check_eq({pfx, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    check_eq({pfx, "_res_candidate"}, 32'(bus.res_candidate), 32'd0);
    check_eq({pfx, "_res_tag"}, 32'(bus.res_tag), 32'd0);
    check_eq({pfx, "_res_mode"}, 32'(bus.res_mode), 32'd0);
    check_eq({pfx, "_res_err"}, 32'(bus.res_err), 32'd0);
  endtask

  // main sequence
  initial begin
    int snap;
    int cnt_bad;
    logic [TAG_W-1:0] tag0;
    rst = 1'b1;
    bus.job_valid   = 1'b0;
    bus.job_central = 24'h000000;
    bus.job_radius  = 12'h000;
    bus.job_mode    = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // single job with fixed candidate and latency
    ovr_en = 1'b1; ovr_val = 8'd29; lat_min = 10; lat_max = 10; rdy_pct = 100;
    push_job(24'h445566, 12'h333, 2'd0);
    check_eq("lat_en_t", 32'(bus.set_en), 32'd0);
    @(posedge clk); #1;
    check_eq("lat_en_t1", 32'(bus.set_en), 32'd1);
    @(posedge clk); #1;
    check_eq("lat_en_t2", 32'(bus.set_en), 32'd0);
    wait_results(1, 60);
    @(negedge clk);
    check_eq("res_valid_falls", 32'(bus.res_valid), 32'd0);
    ovr_en = 1'b0;

    // reset while a job is in flight and another is buffered
    lat_min = 12; lat_max = 12;
    push_rand();
    push_rand();
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("midrst");
    rst = 1'b0;
    snap = n_en;
    repeat (20) @(posedge clk);
    check_eq("rst_fifo_flushed", 32'(n_en - snap), 32'd0);
    check_eq("rst_no_result", 32'(n_results), 32'd1);

    // backpressure: SET busy, fill FIFO, fifth job refused
    lat_min = 1; lat_max = 4;
    busy_force = 1'b1;
    repeat (2) @(posedge clk);
    snap = n_en;
    for (int i = 0; i < 4; i++) push_rand();
    @(negedge clk);
    check_eq("full_ready_low", 32'(bus.job_ready), 32'd0);
    @(posedge clk); #1;
    bus.job_valid = 1'b1;
    bus.job_central = 24'hABCDEF;
    repeat (3) begin
      @(negedge clk);
      check_eq("full_refuses", 32'(bus.job_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.job_valid = 1'b0;
    check_eq("busy_no_issue", 32'(n_en - snap), 32'd0);
    check_eq("bp_accepted", 32'(push_seq), 32'd4);
    busy_force = 1'b0;
    wait_results(5, 300);

    // result stall: consumer holds ready low
    rdy_hold_low = 1'b1;
    push_rand();
    push_rand();
    for (int k = 0; k < 100 && !bus.res_valid; k++) @(negedge clk);
    @(negedge clk);
    check_eq("stall_valid_seen", 32'(bus.res_valid), 32'd1);
    snap = n_en;
    tag0 = bus.res_tag;
    cnt_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!bus.res_valid || (bus.res_tag != tag0)) cnt_bad++;
    end
    check_eq("stall_steady", 32'(cnt_bad), 32'd0);
    check_eq("stall_no_en", 32'(n_en - snap), 32'd0);
    rdy_hold_low = 1'b0;
    wait_results(7, 200);
    check_eq("stall_next_en", 32'(n_en - snap), 32'd1);

    // randomized traffic across tag wrap
    lat_min = 1; lat_max = 6; rdy_pct = 70;
    for (int i = 0; i < 70; i++) begin
      if ($urandom_range(7, 0) == 0) begin
        busy_force = 1'b1;
        repeat ($urandom_range(5, 1)) @(posedge clk);
        busy_force = 1'b0;
      end
      if ($urandom_range(3, 0) == 0) repeat ($urandom_range(4, 1)) @(posedge clk);
      push_rand();
    end
    rdy_pct = 100;
    wait_results(77, 3000);
    check_eq("total_pushed", 32'(push_seq), 32'd76);
    check_eq("queues_drained", 32'(issue_q.size() + res_q.size()), 32'd0);

    // SET never answers
    never_respond = 1'b1;
    push_rand();
`ifdef SET_DISP_TIMEOUT_EN
    wait_results(78, 100);
`else
    cnt_bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.res_valid) cnt_bad++;
    end
    check_eq("no_watchdog_res", 32'(cnt_bad), 32'd0);
`endif
    never_respond = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
